// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle for the 2x2 max-pool stage: pixel input, pooled output with row/frame markers,
// frame-abort and busy status.
interface maxpool2x2_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         flush_i;
  logic signed [DATA_WIDTH-1:0] in_data_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic signed [DATA_WIDTH-1:0] out_data_o;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic                         out_eol_o;
  logic                         out_eof_o;
  logic                         busy_o;

  modport slave (
    input  flush_i, in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, out_eol_o, out_eof_o, busy_o
  );

  modport master (
    output flush_i, in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, out_eol_o, out_eof_o, busy_o
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-ordered activation stream.
// Even rows leave pairwise maxima in a half-width row buffer; odd rows finish each block.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26
) (
  input logic               clk_i,
  input logic               rst_i,
  maxpool2x2_stream_if.slave strm
);

  localparam int POOL_W = IMG_WIDTH / 2;
  localparam int POOL_H = IMG_HEIGHT / 2;
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int BUF_AW = (POOL_W > 1) ? $clog2(POOL_W) : 1;
  localparam bit ODD_W  = (IMG_WIDTH % 2) != 0;
  localparam bit ODD_H  = (IMG_HEIGHT % 2) != 0;

  localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0]  ROW_POOL_LAST = ROW_W'(2 * POOL_H - 1);
  localparam logic [BUF_AW-1:0] BUF_LAST      = BUF_AW'(POOL_W - 1);

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [COL_W-1:0]             col_p0;
  logic [ROW_W-1:0]             row_p0;
  logic signed [DATA_WIDTH-1:0] hold_p0;
  logic signed [DATA_WIDTH-1:0] rowbuf [POOL_W];

  logic signed [DATA_WIDTH-1:0] out_data_p1;
  logic                         vld_p1;
  logic                         eol_p1;
  logic                         eof_p1;
  logic                         busy_q;

  logic                         accept;
  logic                         col_last;
  logic                         in_pool;
  logic [BUF_AW-1:0]            buf_idx;
  logic signed [DATA_WIDTH-1:0] pair_max;
  logic signed [DATA_WIDTH-1:0] blk_max;
  logic                         wr_buf;
  logic                         ld_out;

  // Stage 0: accept, position tracking, pairwise max against the held even-column pixel
  assign strm.in_ready_o = !rst_i && !strm.flush_i && (!vld_p1 || strm.out_ready_i);
  assign accept   = strm.in_valid_i && strm.in_ready_o;
  assign col_last = (col_p0 == COL_LAST);
  // Trailing odd column/row is consumed but never touches hold, buffer or output.
  assign in_pool  = !(ODD_W && col_last) && !(ODD_H && (row_p0 == ROW_LAST));
  assign buf_idx  = BUF_AW'(col_p0 >> 1);
  assign pair_max = smax(hold_p0, strm.in_data_i);
  assign blk_max  = smax(pair_max, rowbuf[buf_idx]);
  assign wr_buf   = accept && in_pool && !row_p0[0] && col_p0[0];
  assign ld_out   = accept && in_pool && row_p0[0] && col_p0[0];

  always_ff @(posedge clk_i) begin
    if (rst_i || strm.flush_i) begin
      col_p0      <= '0;
      row_p0      <= '0;
      hold_p0     <= '0;
      out_data_p1 <= '0;
      vld_p1      <= 1'b0;
      eol_p1      <= 1'b0;
      eof_p1      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (accept) begin
        if (col_last) begin
          col_p0 <= '0;
          row_p0 <= (row_p0 == ROW_LAST) ? '0 : row_p0 + ROW_W'(1);
        end else begin
          col_p0 <= col_p0 + COL_W'(1);
        end
      end

      if (accept && in_pool && !col_p0[0]) begin
        hold_p0 <= strm.in_data_i;
      end

      // Stage 1: output register, holds its beat until the consumer takes it
      if (ld_out) begin
        vld_p1      <= 1'b1;
        out_data_p1 <= blk_max;
        eol_p1      <= (buf_idx == BUF_LAST);
        eof_p1      <= (buf_idx == BUF_LAST) && (row_p0 == ROW_POOL_LAST);
      end else if (strm.out_ready_i) begin
        vld_p1 <= 1'b0;
      end

      // A new frame starting on the same edge as the old eof handshake keeps busy high.
      if (vld_p1 && strm.out_ready_i && eof_p1) begin
        busy_q <= 1'b0;
      end
      if (accept && (col_p0 == '0) && (row_p0 == '0)) begin
        busy_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_buf) begin
      rowbuf[buf_idx] <= pair_max;
    end
  end

  assign strm.out_data_o  = out_data_p1;
  assign strm.out_valid_o = vld_p1;
  assign strm.out_eol_o   = eol_p1;
  assign strm.out_eof_o   = eof_p1;
  assign strm.busy_o      = busy_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: a 4x4 and a 5x3 instance share one stimulus driver (sel picks
// which one is fed and observed); expected beats come from a block-wise max over each frame.
`timescale 1ns/1ps
module tb_maxpool2x2_stream;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 sel;
  logic                 vi;
  logic signed [DW-1:0] din;
  logic                 ro;
  logic                 flush;

  maxpool2x2_stream_if #(.DATA_WIDTH(DW)) if_a ();
  maxpool2x2_stream_if #(.DATA_WIDTH(DW)) if_b ();

  assign if_a.flush_i     = flush;
  assign if_a.in_data_i   = din;
  assign if_a.in_valid_i  = vi && !sel;
  assign if_a.out_ready_i = ro;
  assign if_b.flush_i     = flush;
  assign if_b.in_data_i   = din;
  assign if_b.in_valid_i  = vi && sel;
  assign if_b.out_ready_i = ro;

  maxpool2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .strm(if_a)
  );
  maxpool2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .strm(if_b)
  );

  logic                 ri, vo, eol, eof, busy;
  logic signed [DW-1:0] dout;
  assign ri   = sel ? if_b.in_ready_o  : if_a.in_ready_o;
  assign vo   = sel ? if_b.out_valid_o : if_a.out_valid_o;
  assign dout = sel ? if_b.out_data_o  : if_a.out_data_o;
  assign eol  = sel ? if_b.out_eol_o   : if_a.out_eol_o;
  assign eof  = sel ? if_b.out_eof_o   : if_a.out_eof_o;
  assign busy = sel ? if_b.busy_o      : if_a.busy_o;

  typedef struct {
    logic signed [DW-1:0] d;
    logic                 eol;
    logic                 eof;
  } beat_t;

  beat_t                exp_q[$];
  logic signed [DW-1:0] frame[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  bit                   busy_m, acc_prev, prod_prev, stall_prev, cur_prod, cur_first;
  logic signed [DW-1:0] sv_d;
  logic                 sv_eol, sv_eof;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: every complete 2x2 block in raster order, partial blocks at the edges dropped.
  function automatic void push_expected(input int w, input int h);
    beat_t b;
    logic signed [DW-1:0] m;
    for (int by = 0; by < h / 2; by++) begin
      for (int bx = 0; bx < w / 2; bx++) begin
        m = frame[2*by*w + 2*bx];
        if (frame[2*by*w + 2*bx + 1] > m)     m = frame[2*by*w + 2*bx + 1];
        if (frame[(2*by+1)*w + 2*bx] > m)     m = frame[(2*by+1)*w + 2*bx];
        if (frame[(2*by+1)*w + 2*bx + 1] > m) m = frame[(2*by+1)*w + 2*bx + 1];
        b.d   = m;
        b.eol = (bx == w / 2 - 1);
        b.eof = (bx == w / 2 - 1) && (by == h / 2 - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic fill_seq(input int n);
    frame.delete();
    for (int i = 1; i <= n; i++) frame.push_back(DW'(i));
  endtask

  task automatic fill_rand(input int n);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back($signed($urandom));
  endtask

  // One clock: observe just before the edge at the falling edge, return after the edge.
  task automatic tick(output bit acc);
    beat_t b;
    bit    hs;
    @(negedge clk);
    if (stall_prev) begin
      chk("stall_valid", vo, 1);
      chk("stall_data", dout, sv_d);
      chk("stall_eol", eol, sv_eol);
      chk("stall_eof", eof, sv_eof);
    end
    if (acc_prev) chk("latency_valid", vo, prod_prev);
    chk("busy", busy, busy_m);
    if (vo && !ro) chk("bp_in_ready", ri, 0);
    hs  = vo && ro;
    acc = vi && ri;
    if (hs) begin
      chk("out_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("out_data", dout, b.d);
        chk("out_eol", eol, b.eol);
        chk("out_eof", eof, b.eof);
        if (b.eof) busy_m = 1'b0;
      end
    end
    stall_prev = vo && !ro;
    sv_d       = dout;
    sv_eol     = eol;
    sv_eof     = eof;
    acc_prev   = acc;
    prod_prev  = acc && cur_prod;
    if (acc && cur_first) busy_m = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high; 1: random ready and input gaps; 2: one 3-cycle stall on first output
  task automatic send_frame(input int w, input int h, input int mode, input int npix, input bit push);
    int stall_left;
    bit stalled_once;
    bit acc;
    int waitc;
    int r, c;
    stall_left   = 0;
    stalled_once = 1'b0;
    if (push) push_expected(w, h);
    for (int i = 0; i < npix; i++) begin
      r = i / w;
      c = i % w;
      cur_first = (i == 0);
      cur_prod  = (r < 2 * (h / 2)) && (c < 2 * (w / 2)) && (r % 2 == 1) && (c % 2 == 1);
      if (mode == 1) begin
        while ($urandom_range(0, 3) == 0) begin
          vi = 1'b0;
          ro = ($urandom_range(0, 3) != 0);
          tick(acc);
        end
      end
      din   = frame[i];
      vi    = 1'b1;
      waitc = 0;
      acc   = 1'b0;
      while (!acc && waitc < 60) begin
        if (mode == 0) begin
          ro = 1'b1;
        end else if (mode == 1) begin
          ro = ($urandom_range(0, 3) != 0);
        end else begin
          if (!stalled_once && vo) begin
            stall_left   = 3;
            stalled_once = 1'b1;
          end
          ro = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        tick(acc);
        waitc++;
      end
      if (!acc) begin
        chk("accept_timeout", acc, 1);
        break;
      end
    end
    vi = 1'b0;
  endtask

  task automatic drain();
    bit a;
    vi = 1'b0;
    ro = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick(a);
    tick(a);
    tick(a);
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    bit a;
    rst = 1'b1; sel = 1'b0; vi = 1'b0; din = '0; ro = 1'b1; flush = 1'b0;
    busy_m = 1'b0; acc_prev = 1'b0; prod_prev = 1'b0; stall_prev = 1'b0;
    cur_prod = 1'b0; cur_first = 1'b0;

    // Reset state of both instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", vo, 0);
    chk("rst_data", dout, 0);
    chk("rst_eol", eol, 0);
    chk("rst_eof", eof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", ri, 0);
    sel = 1'b1;
    #1;
    chk("rst_b_valid", vo, 0);
    chk("rst_b_busy", busy, 0);
    sel = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("idle_in_ready", ri, 1);

    // 4x4 ramp, full throughput
    fill_seq(16);
    send_frame(4, 4, 0, 16, 1);
    drain();

    // 5x3 ramp: trailing column and row discarded
    sel = 1'b1;
    fill_seq(15);
    send_frame(5, 3, 0, 15, 1);
    drain();
    sel = 1'b0;

    // Signed blocks including the most negative and most positive values
    frame.delete();
    for (int i = 0; i < 16; i++) frame.push_back($signed($urandom));
    frame[0] = -5;   frame[1] = -3;            frame[4] = -8; frame[5] = -1;
    frame[2] = -128; frame[3] = 32'sh7FFFFFFF; frame[6] = 5;  frame[7] = 0;
    frame[8] = 32'sh80000000; frame[9] = 32'sh80000001; frame[12] = -2; frame[13] = -7;
    send_frame(4, 4, 0, 16, 1);
    drain();

    // Output backpressure for 3 cycles mid-frame
    fill_seq(16);
    send_frame(4, 4, 2, 16, 1);
    drain();

    // Back-to-back frames with no idle gap
    fill_seq(16);
    for (int i = 0; i < 16; i++) frame[i] = 100 - i;
    send_frame(4, 4, 0, 16, 1);
    fill_rand(16);
    send_frame(4, 4, 0, 16, 1);
    drain();

    // Flush after 6 pixels, then a fresh frame
    fill_seq(16);
    send_frame(4, 4, 0, 6, 0);
    flush = 1'b1;
    vi    = 1'b0;
    ro    = 1'b0;
    tick(a);
    flush      = 1'b0;
    stall_prev = 1'b0;
    acc_prev   = 1'b0;
    busy_m     = 1'b0;
    chk("flush_valid", vo, 0);
    chk("flush_busy", busy, 0);
    ro = 1'b1;
    fill_seq(16);
    send_frame(4, 4, 0, 16, 1);
    drain();

    // Randomized data with random gaps and ready
    for (int f = 0; f < 4; f++) begin
      fill_rand(16);
      send_frame(4, 4, 1, 16, 1);
    end
    drain();
    sel = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fill_rand(15);
      send_frame(5, 3, 1, 15, 1);
    end
    drain();
    sel = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
